mc_control: RTL and testbench

- Moore-style main control FSM (Mealy only on `mem_ready` and `zero`) for the multi-cycle MIPS datapath.
- Sequences the shared PC / IR / register-file / ALU / unified-memory datapath through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states, one instruction at a time.
- Handles variable-latency memory through a `mem_ready` handshake with a watchdog.
- Sits beside the datapath top, between the IR opcode/funct fields and every datapath enable and mux select.

---
 rtl/mc_control.sv | 204 ++++++++++++++++++++
 tb/tb_mc_control.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Moore outputs per state, with Mealy terms only on mem_ready and zero, plus a memory watchdog.
//
// state     | meaning
// FETCH     | read instruction at PC, load IR, PC += 4
// DECODE    | branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | effective address into ALUOut
// MEM_READ  | load data from memory into MDR
// MEM_WB    | MDR into rt
// MEM_WRITE | store B to memory
// R_EXEC    | R-type ALU operation
// R_WB      | ALUOut into rd
// BRANCH    | compare rs/rt, conditionally load branch target
// JUMP      | j / jal
// I_EXEC    | addi ALU operation
// I_WB      | ALUOut into rt
// JR        | PC from rs
// ERR       | illegal opcode or memory timeout, held until reset
module mc_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_re,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       retire,
  output logic       err
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_JR        = 4'd12,
    S_ERR       = 4'd15
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   wd_q, wd_d;
  logic            wait_st, timeout;
  logic            pc_we_c, mem_we_c, ir_we_c, reg_we_c, retire_c;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_FETCH;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  assign timeout = (MEM_TIMEOUT > 0) && wait_st && !mem_ready && (wd_q == TW'(MEM_TIMEOUT));
  assign wd_d    = (wait_st && !mem_ready) ? wd_q + TW'(1) : '0;

  always_comb begin
    state_d    = state_q;
    pc_we_c    = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_re     = 1'b0;
    mem_we_c   = 1'b0;
    ir_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    retire_c   = 1'b0;
    err        = 1'b0;
    if (timeout) begin
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_re    = 1'b1;
          alu_src_b = 2'b01;
          ir_we_c   = mem_ready;
          pc_we_c   = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            6'h23, 6'h2B: state_d = S_MEM_ADDR;
            6'h00:        state_d = (funct == 6'h08) ? S_JR : S_R_EXEC;
            6'h04, 6'h05: state_d = S_BRANCH;
            6'h02, 6'h03: state_d = S_JUMP;
            6'h08:        state_d = S_I_EXEC;
            default:      state_d = S_ERR;
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (opcode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          iord   = 1'b1;
          mem_re = 1'b1;
          if (mem_ready) state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_we_c   = 1'b1;
          mem_to_reg = 2'b01;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEM_WRITE: begin
          iord     = 1'b1;
          mem_we_c = 1'b1;
          retire_c = mem_ready;
          if (mem_ready) state_d = S_FETCH;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_R_WB;
        end
        S_R_WB: begin
          reg_we_c = 1'b1;
          reg_dst  = 2'b01;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          pc_we_c   = (opcode == 6'h04) ? zero : !zero;
          retire_c  = 1'b1;
          state_d   = S_FETCH;
        end
        S_JUMP: begin
          pc_we_c  = 1'b1;
          pc_src   = 2'b10;
          retire_c = 1'b1;
          if (opcode == 6'h03) begin
            reg_we_c   = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
          state_d = S_FETCH;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = S_I_WB;
        end
        S_I_WB: begin
          reg_we_c = 1'b1;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
        S_JR: begin
          pc_we_c  = 1'b1;
          pc_src   = 2'b11;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
        S_ERR: begin
          err = 1'b1;
        end
        default: state_d = S_ERR;
      endcase
    end
  end

  // State resets asynchronously to FETCH, whose outputs depend on mem_ready; mask writes during reset.
  assign pc_we  = RST & pc_we_c;
  assign ir_we  = RST & ir_we_c;
  assign reg_we = RST & reg_we_c;
  assign mem_we = RST & mem_we_c;
  assign retire = RST & retire_c;
  assign state  = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-cycle expected state and control word
// queued when inputs are driven, popped and compared when outputs are sampled.
module tb_mc_control;

  logic       CLK, RST;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_we, iord, mem_re, mem_we, ir_we, reg_we, alu_src_a, retire, err;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
  logic [3:0] state;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord, mem_re, mem_we, ir_we, reg_we;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       retire, err;
  } ctl_t;

  typedef struct {
    string      tag;
    logic [3:0] st;
    ctl_t       c;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mc_control #(.MEM_TIMEOUT(15), .TW(4)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .iord(iord),
    .mem_re(mem_re), .mem_we(mem_we), .ir_we(ir_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .retire(retire), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected control word for a state, written from the per-state output table.
  function automatic ctl_t exp_ctl(input logic [3:0] st, input logic rdy, input logic to, input logic in_rst);
    ctl_t c = '0;
    if (!to) begin
      case (st)
        4'd0:  begin c.mem_re = 1; c.alu_src_b = 2'b01; c.ir_we = rdy; c.pc_we = rdy; end
        4'd1:  c.alu_src_b = 2'b11;
        4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
        4'd3:  begin c.iord = 1; c.mem_re = 1; end
        4'd4:  begin c.reg_we = 1; c.mem_to_reg = 2'b01; c.retire = 1; end
        4'd5:  begin c.iord = 1; c.mem_we = 1; c.retire = rdy; end
        4'd6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
        4'd7:  begin c.reg_we = 1; c.reg_dst = 2'b01; c.retire = 1; end
        4'd8:  begin
          c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.retire = 1;
          c.pc_we = (opcode == 6'h04) ? zero : ~zero;
        end
        4'd9:  begin
          c.pc_we = 1; c.pc_src = 2'b10; c.retire = 1;
          if (opcode == 6'h03) begin c.reg_we = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; end
        end
        4'd10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
        4'd11: begin c.reg_we = 1; c.retire = 1; end
        4'd12: begin c.pc_we = 1; c.pc_src = 2'b11; c.retire = 1; end
        4'd15: c.err = 1;
        default: c = '0;
      endcase
    end
    if (in_rst) begin
      c.pc_we = 0; c.ir_we = 0; c.reg_we = 0; c.mem_we = 0; c.retire = 0;
    end
    return c;
  endfunction

  // One clock cycle: called just after a falling edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic rdy, input logic z, input logic to = 1'b0);
    exp_t e, got_e;
    ctl_t obs;
    mem_ready = rdy;
    zero      = z;
    e.tag = tag;
    e.st  = st;
    e.c   = exp_ctl(st, rdy, to, !RST);
    sb_q.push_back(e);
    #2;
    obs = '{pc_we, pc_src, iord, mem_re, mem_we, ir_we, reg_we, reg_dst, mem_to_reg,
            alu_src_a, alu_src_b, alu_op, retire, err};
    got_e = sb_q.pop_front();
    check_eq({got_e.tag, ".state"}, 32'(state), 32'(got_e.st));
    check_eq({got_e.tag, ".ctl"}, 32'(obs), 32'(got_e.c));
    @(negedge CLK);
  endtask

  task automatic set_ins(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  initial begin
    RST = 1'b1; opcode = '0; funct = '0; zero = 0; mem_ready = 1;
    #1 RST = 1'b0;
    @(negedge CLK);
    repeat (3) cyc("reset", 4'd0, 1'b1, 1'b0);
    RST = 1'b1;

    set_ins(6'h00, 6'h20);
    cyc("add.f", 0, 1, 0); cyc("add.d", 1, 1, 0); cyc("add.ex", 6, 1, 0); cyc("add.wb", 7, 1, 0);

    set_ins(6'h23, 6'h00);
    cyc("lw.f", 0, 1, 0); cyc("lw.d", 1, 1, 0); cyc("lw.ma", 2, 1, 0);
    for (int i = 0; i < 3; i++) cyc("lw.wait", 3, 0, 0);
    cyc("lw.mr", 3, 1, 0); cyc("lw.wb", 4, 1, 0);

    set_ins(6'h04, 6'h00);
    cyc("beq0.f", 0, 1, 0); cyc("beq0.d", 1, 1, 0); cyc("beq0.br", 8, 1, 0);
    cyc("beq1.f", 0, 1, 1); cyc("beq1.d", 1, 1, 1); cyc("beq1.br", 8, 1, 1);
    set_ins(6'h05, 6'h00);
    cyc("bne0.f", 0, 1, 0); cyc("bne0.d", 1, 1, 0); cyc("bne0.br", 8, 1, 0);
    cyc("bne1.f", 0, 1, 1); cyc("bne1.d", 1, 1, 1); cyc("bne1.br", 8, 1, 1);

    set_ins(6'h08, 6'h00);
    cyc("addi.f", 0, 1, 0); cyc("addi.d", 1, 1, 0); cyc("addi.ex", 10, 1, 0); cyc("addi.wb", 11, 1, 0);

    set_ins(6'h02, 6'h00);
    cyc("j.f", 0, 1, 0); cyc("j.d", 1, 1, 0); cyc("j.j", 9, 1, 0);
    set_ins(6'h03, 6'h00);
    cyc("jal.f", 0, 1, 0); cyc("jal.d", 1, 1, 0); cyc("jal.j", 9, 1, 0);
    set_ins(6'h00, 6'h08);
    cyc("jr.f", 0, 1, 0); cyc("jr.d", 1, 1, 0); cyc("jr.jr", 12, 1, 0);

    set_ins(6'h2B, 6'h00);
    cyc("sw.f", 0, 1, 0); cyc("sw.d", 1, 1, 0); cyc("sw.ma", 2, 1, 0);
    cyc("sw.wait", 5, 0, 0); cyc("sw.mw", 5, 1, 0);

    // Reset pulsed while a store is still waiting on memory.
    cyc("swr.f", 0, 1, 0); cyc("swr.d", 1, 1, 0); cyc("swr.ma", 2, 1, 0);
    mem_ready = 0;
    #2;
    check_eq("swr.pre_state", 32'(state), 32'd5);
    check_eq("swr.pre_mem_we", 32'(mem_we), 32'd1);
    #1 RST = 1'b0;
    #1;
    check_eq("swr.rst_state", 32'(state), 32'd0);
    check_eq("swr.rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("swr.rst_err", 32'(err), 32'd0);
    @(negedge CLK);
    cyc("swr.hold", 0, 1, 0);
    RST = 1'b1;

    // Watchdog: ready arriving on the limit cycle wins, then illegal opcode.
    set_ins(6'h3F, 6'h00);
    for (int i = 0; i < 15; i++) cyc("wdw.wait", 0, 0, 0);
    cyc("wdw.rdy", 0, 1, 0);
    cyc("ill.d", 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc("ill.err", 15, 1, 0);
    RST = 1'b0;
    cyc("ill.rst", 0, 1, 0);
    RST = 1'b1;

    // Watchdog: 16 not-ready FETCH cycles then ERR, sticky.
    set_ins(6'h00, 6'h20);
    for (int i = 0; i < 15; i++) cyc("wd.wait", 0, 0, 0);
    cyc("wd.limit", 0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) cyc("wd.err", 15, (i > 1), 0);

    check_eq("sb.empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
